// File: rtl/instr_mem_responder_if.sv
`default_nettype none
// ============================================================================
// instr_mem_responder_if : fetch request/response, flush and program-load bus
// Revision: 1.0
// ============================================================================
interface instr_mem_responder_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_instr;
   logic [31:0] resp_addr;
   logic        resp_err;
   logic        flush;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;

   modport master (
      output req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
      input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
   );

   modport slave (
      input  req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
      output req_ready, resp_valid, resp_instr, resp_addr, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// instr_mem_responder : word-addressed instruction store with pipelined fetch,
// in-order output FIFO with backpressure, flush and program-load port.
// Revision: 1.0
// ============================================================================
module instr_mem_responder #(
   parameter int          DEPTH_WORDS = 256,
   parameter int          LATENCY     = 2,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_mem_responder_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [31:0] addr;
      logic        err;
      logic [31:0] instr;
   } entry_t;

   logic [31:0]      mem_q [DEPTH_WORDS];

   logic [IDX_W-1:0] req_idx;
   logic             req_err;
   logic             accept;
   logic             req_ready_w;
   entry_t           req_entry;

   logic             push_vld;
   entry_t           push_entry;
   logic [CNT_W-1:0] inflight;

   entry_t           fifo_q [FIFO_DEPTH];
   entry_t           fifo_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_idx;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pop;
   logic             resp_valid_w;
   entry_t           head;

   logic [IDX_W-1:0] load_idx;
   logic             mem_we;
   logic             unused_load_lsb;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Memory is read combinationally in the acceptance cycle, so a same-edge
   // load is seen only by later requests.
   always_comb begin
      req_idx         = bus.req_addr[IDX_W+1:2];
      req_err         = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:IDX_W+2] != '0);
      req_ready_w     = ({1'b0, count_q} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH);
      accept          = bus.req_valid && req_ready_w;
      req_entry.addr  = bus.req_addr;
      req_entry.err   = req_err;
      req_entry.instr = req_err ? NOP_INSTR : mem_q[req_idx];
   end

   generate
      if (LATENCY > 1) begin : g_pipe
         localparam int STAGES = LATENCY - 1;
         logic [STAGES-1:0] vld_q, vld_d;
         entry_t            ent_q [STAGES];
         entry_t            ent_d [STAGES];

         // Stage 0 always takes the new request, even during a flush: that
         // request is the redirect target.
         always_comb begin
            vld_d    = '0;
            vld_d[0] = accept;
            ent_d[0] = req_entry;
            for (int i = 1; i < STAGES; i++) begin
               vld_d[i] = vld_q[i-1] && !bus.flush;
               ent_d[i] = ent_q[i-1];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vld_q <= '0;
               for (int i = 0; i < STAGES; i++) begin
                  ent_q[i] <= '0;
               end
            end else begin
               vld_q <= vld_d;
               ent_q <= ent_d;
            end
         end

         assign push_vld   = vld_q[STAGES-1] && !bus.flush;
         assign push_entry = ent_q[STAGES-1];
         assign inflight   = CNT_W'($countones(vld_q));
      end else begin : g_direct
         assign push_vld   = accept;
         assign push_entry = req_entry;
         assign inflight   = '0;
      end
   endgenerate

   always_comb begin
      resp_valid_w = (count_q != '0);
      pop          = resp_valid_w && bus.resp_ready;
      wr_idx       = bus.flush ? '0 : wr_ptr_q;
      fifo_d       = fifo_q;
      if (push_vld) begin
         fifo_d[wr_idx] = push_entry;
      end
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = push_vld ? ptr_inc('0) : '0;
         count_d  = push_vld ? CNT_W'(1) : '0;
      end else begin
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         if (push_vld) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         case ({push_vld, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         fifo_q   <= fifo_d;
      end
   end

   // Outputs are forced to zero while empty so reset/flush leave a clean bus.
   always_comb begin
      head           = fifo_q[rd_ptr_q];
      bus.req_ready  = req_ready_w;
      bus.resp_valid = resp_valid_w;
      bus.resp_instr = resp_valid_w ? head.instr : '0;
      bus.resp_addr  = resp_valid_w ? head.addr  : '0;
      bus.resp_err   = resp_valid_w && head.err;
   end

   always_comb begin
      load_idx        = bus.load_addr[IDX_W+1:2];
      mem_we          = bus.load_en && (bus.load_addr[31:IDX_W+2] == '0);
      unused_load_lsb = &{1'b0, bus.load_addr[1:0]};
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[load_idx] <= bus.load_data;
      end
   end

endmodule
`default_nettype wire
